shift_seq_4bit: RTL and testbench

- Sequential multi-step shifter that sits directly downstream of the combinational single-bit shift stage.
- Accepts a nibble plus a shift amount and direction over a valid/ready handshake.
- Applies one single-bit shift per clock until the amount is exhausted.
- Presents the result on a valid/ready output port, with backpressure, to the next stage.

---
 rtl/shift_seq_4bit.sv | 112 +++++++++++
 tb/tb_shift_seq_4bit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_4bit.sv
// rtl/shift_seq_4bit.sv - multi-cycle one-bit-per-clock shifter with valid/ready ports
// Optional rotate mode: define SHIFT_SEQ_ROTATE_EN to add in_rot.
module shift_seq_4bit #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_amt,
  input  logic             in_dir,
`ifdef SHIFT_SEQ_ROTATE_EN
  input  logic             in_rot,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] data_q, data_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             dir_q, dir_nxt;
  logic             rot_q;
  logic             fill_l, fill_r;
  logic             accept;

  assign accept    = (state == IDLE) && in_valid;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = data_q;

`ifdef SHIFT_SEQ_ROTATE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_q <= 1'b0;
    end else if (accept) begin
      rot_q <= in_rot;
    end
  end
`else
  assign rot_q = 1'b0;
`endif

  // Vacated bit: zero for a logical shift, the bit falling off the other end for a rotate.
  assign fill_l = rot_q & data_q[WIDTH-1];
  assign fill_r = rot_q & data_q[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    data_nxt  = data_q;
    cnt_nxt   = cnt_q;
    dir_nxt   = dir_q;
    case (state)
      IDLE: begin
        if (in_valid) begin
          data_nxt  = in_data;
          cnt_nxt   = in_amt;
          dir_nxt   = in_dir;
          state_nxt = (in_amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_nxt = dir_q ? {fill_r, data_q[WIDTH-1:1]} : {data_q[WIDTH-2:0], fill_l};
        cnt_nxt  = cnt_q - 1'b1;
        // A zero count here is unreachable; treat it as finished rather than wrap.
        if ((cnt_q == CNT_W'(1)) || (cnt_q == '0)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
      dir_q  <= 1'b0;
    end else begin
      data_q <= data_nxt;
      cnt_q  <= cnt_nxt;
      dir_q  <= dir_nxt;
    end
  end

endmodule

// File: tb/tb_shift_seq_4bit.sv
// tb/tb_shift_seq_4bit.sv - self-checking bench for shift_seq_4bit
// Rotate vectors are included when SHIFT_SEQ_ROTATE_EN is defined.
module tb_shift_seq_4bit;

  typedef struct {
    logic [3:0] data;
    logic [1:0] amt;
    logic       dir;
    logic       rot;
    logic [3:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [1:0] in_amt;
  logic       in_dir;
`ifdef SHIFT_SEQ_ROTATE_EN
  logic       in_rot;
`endif
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_q[$];
  vec_t       vecs[$];

  shift_seq_4bit #(.WIDTH(4), .CNT_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_dir    (in_dir),
`ifdef SHIFT_SEQ_ROTATE_EN
    .in_rot    (in_rot),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every result handoff pops the oldest expected value.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h expected none", out_data);
      end else begin
        check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic wait_in_ready();
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    in_data  = v.data;
    in_amt   = v.amt;
    in_dir   = v.dir;
`ifdef SHIFT_SEQ_ROTATE_EN
    in_rot   = v.rot;
`endif
    exp_q.push_back(v.exp);
  endtask

  task automatic run_op(input vec_t v);
    int lat = 0;
    wait_in_ready();
    drive(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 4'($urandom);
    in_dir   = ~v.dir;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check("latency", 32'(lat), 32'(v.amt) + 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("in_ready_after_handoff", 32'(in_ready), 32'd1);
    check("busy_after_handoff", 32'(busy), 32'd0);
  endtask

  initial begin
    vecs.push_back(vec_t'{4'b0010, 2'd1, 1'b0, 1'b0, 4'b0100});
    vecs.push_back(vec_t'{4'b1000, 2'd1, 1'b0, 1'b0, 4'b0000});
    vecs.push_back(vec_t'{4'b1111, 2'd1, 1'b1, 1'b0, 4'b0111});
    vecs.push_back(vec_t'{4'b1001, 2'd3, 1'b1, 1'b0, 4'b0001});
    vecs.push_back(vec_t'{4'b1001, 2'd0, 1'b1, 1'b0, 4'b1001});
    vecs.push_back(vec_t'{4'b0001, 2'd3, 1'b0, 1'b0, 4'b1000});
    vecs.push_back(vec_t'{4'b1011, 2'd2, 1'b0, 1'b0, 4'b1100});
    vecs.push_back(vec_t'{4'b1011, 2'd2, 1'b1, 1'b0, 4'b0010});
    vecs.push_back(vec_t'{4'b0110, 2'd3, 1'b1, 1'b0, 4'b0000});
`ifdef SHIFT_SEQ_ROTATE_EN
    vecs.push_back(vec_t'{4'b1001, 2'd1, 1'b0, 1'b1, 4'b0011});
    vecs.push_back(vec_t'{4'b1001, 2'd1, 1'b1, 1'b1, 4'b1100});
    vecs.push_back(vec_t'{4'b1001, 2'd3, 1'b0, 1'b1, 4'b1100});
    vecs.push_back(vec_t'{4'b0110, 2'd2, 1'b1, 1'b1, 4'b1001});
    vecs.push_back(vec_t'{4'b1001, 2'd1, 1'b0, 1'b0, 4'b0010});
`endif

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    in_amt    = 2'd0;
    in_dir    = 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
    in_rot    = 1'b0;
`endif
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i]) run_op(vecs[i]);

    // Backpressure on a zero-amount result.
    out_ready = 1'b0;
    wait_in_ready();
    drive(vec_t'{4'b1001, 2'd0, 1'b0, 1'b0, 4'b1001});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_valid_first", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_data", 32'(out_data), 32'b1001);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-shift discards the operation.
    wait_in_ready();
    in_valid = 1'b1;
    in_data  = 4'b1111;
    in_amt   = 2'd3;
    in_dir   = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_out_data", 32'(out_data), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(vec_t'{4'b0101, 2'd2, 1'b1, 1'b0, 4'b0001});

    // in_valid held with a new operand while busy: only taken once IDLE.
    wait_in_ready();
    drive(vec_t'{4'b1001, 2'd3, 1'b1, 1'b0, 4'b0001});
    @(posedge clk);
    #1;
    drive(vec_t'{4'b0110, 2'd1, 1'b0, 1'b0, 4'b1100});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("held_first_valid", 32'(out_valid), 32'd1);
    check("held_in_ready_done", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("held_first_idle", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("held_accepted", 32'(busy), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
